ram_arbiter: RTL and testbench

- Shares the single-port data RAM (256 x 32, asynchronous read, synchronous write) between the processor data port and a secondary bus master (UART loader / debug port) through a request/ack handshake.
- Sits between the processor core, the RAM instance and the external master.
- The processor has fixed priority.
- The block stalls the processor only when the external master holds the RAM.

---
 rtl/ram_arbiter.sv | 118 +++++++++++
 tb/tb_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (fixed priority) and an external master.
// Optional starvation guard enabled by defining RAM_ARB_STARVE_GUARD_EN.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  input  logic              cpu_mem_en_pi,
  input  logic              cpu_mem_write_pi,
  input  logic [31:0]       cpu_adr_pi,
  input  logic [DATA_W-1:0] cpu_wdata_pi,
  output logic [DATA_W-1:0] cpu_rdata_po,
  output logic              cpu_stall_po,
  input  logic              ext_req_pi,
  input  logic              ext_we_pi,
  input  logic [ADDR_W-1:0] ext_adr_pi,
  input  logic [DATA_W-1:0] ext_wdata_pi,
  output logic              ext_gnt_po,
  output logic              ext_ack_po,
  output logic [DATA_W-1:0] ext_rdata_po,
  output logic              ram_we_po,
  output logic [ADDR_W-1:0] ram_a_po,
  output logic [DATA_W-1:0] ram_d_po,
  input  logic [DATA_W-1:0] ram_spo_pi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT_ACC = 2'd1,
    EXT_ACK = 2'd2
  } state_t;

  state_t state, state_next;
  logic   force_grant;
  logic   ram_we_c;

  // Byte-lane bits and address bits beyond the RAM depth are intentionally dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{cpu_adr_pi[31:ADDR_W+2], cpu_adr_pi[1:0]};

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int            CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      wait_cnt <= '0;
    end else if (state == IDLE && state_next == EXT_ACC) begin
      wait_cnt <= '0;
    end else if (state == IDLE && ext_req_pi && cpu_mem_en_pi && wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_grant = (wait_cnt == MAX_CNT);
`else
  localparam bit unused_max_wait_ok = (MAX_WAIT > 0);
  assign force_grant = 1'b0;
`endif

  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read data is captured only on external reads; writes leave the last value in place.
  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      ext_rdata_po <= '0;
    end else if (state == EXT_ACC && !ext_we_pi) begin
      ext_rdata_po <= ram_spo_pi;
    end
  end

  always_comb begin
    state_next   = state;
    ext_gnt_po   = 1'b0;
    ext_ack_po   = 1'b0;
    cpu_stall_po = 1'b0;
    ram_a_po     = cpu_adr_pi[ADDR_W+1:2];
    ram_d_po     = cpu_wdata_pi;
    ram_we_c     = cpu_mem_write_pi & cpu_mem_en_pi;
    case (state)
      IDLE: begin
        if (ext_req_pi && (!cpu_mem_en_pi || force_grant)) begin
          state_next = EXT_ACC;
        end
      end
      EXT_ACC: begin
        ext_gnt_po   = 1'b1;
        cpu_stall_po = cpu_mem_en_pi;
        ram_a_po     = ext_adr_pi;
        ram_d_po     = ext_wdata_pi;
        ram_we_c     = ext_we_pi;
        state_next   = EXT_ACK;
      end
      EXT_ACK: begin
        ext_ack_po = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gating with reset keeps a CPU store from reaching the RAM while reset is held.
  assign ram_we_po    = ram_we_c & reset_pi;
  assign cpu_rdata_po = ram_spo_pi;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus hand-written reset, spacing and starvation sequences.
// Drives a behavioural 256 x 32 RAM from the arbiter's RAM port.
module tb_ram_arbiter;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic        cpu_mem_en_pi, cpu_mem_write_pi;
  logic [31:0] cpu_adr_pi, cpu_wdata_pi, cpu_rdata_po;
  logic        cpu_stall_po;
  logic        ext_req_pi, ext_we_pi;
  logic [7:0]  ext_adr_pi;
  logic [31:0] ext_wdata_pi, ext_rdata_po;
  logic        ext_gnt_po, ext_ack_po;
  logic        ram_we_po;
  logic [7:0]  ram_a_po;
  logic [31:0] ram_d_po, ram_spo_pi;

  logic [31:0] mem [256];
  int vectors_applied = 0;
  int miscompares = 0;

  ram_arbiter dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi),
    .cpu_mem_en_pi(cpu_mem_en_pi), .cpu_mem_write_pi(cpu_mem_write_pi),
    .cpu_adr_pi(cpu_adr_pi), .cpu_wdata_pi(cpu_wdata_pi),
    .cpu_rdata_po(cpu_rdata_po), .cpu_stall_po(cpu_stall_po),
    .ext_req_pi(ext_req_pi), .ext_we_pi(ext_we_pi),
    .ext_adr_pi(ext_adr_pi), .ext_wdata_pi(ext_wdata_pi),
    .ext_gnt_po(ext_gnt_po), .ext_ack_po(ext_ack_po), .ext_rdata_po(ext_rdata_po),
    .ram_we_po(ram_we_po), .ram_a_po(ram_a_po), .ram_d_po(ram_d_po),
    .ram_spo_pi(ram_spo_pi)
  );

  always #50 clk_pi = ~clk_pi;

  // Behavioural RAM: asynchronous read, synchronous write.
  always @(posedge clk_pi) if (ram_we_po) mem[ram_a_po] <= ram_d_po;
  assign ram_spo_pi = mem[ram_a_po];

  typedef struct {
    bit        cpu_en;
    bit        cpu_we;
    bit [31:0] cpu_adr;
    bit [31:0] cpu_wdata;
    bit        ext_req;
    bit        ext_we;
    bit [7:0]  ext_adr;
    bit [31:0] ext_wdata;
    bit        e_gnt;
    bit        e_ack;
    bit        e_stall;
    bit        e_we;
    bit [7:0]  e_a;
    bit        chk_xr;
    bit [31:0] e_xr;
    bit        chk_cr;
    bit [31:0] e_cr;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input bit en, input bit we, input bit [31:0] adr, input bit [31:0] wd,
                               input bit req, input bit xwe, input bit [7:0] xadr, input bit [31:0] xwd);
    cpu_mem_en_pi    = en;
    cpu_mem_write_pi = we;
    cpu_adr_pi       = adr;
    cpu_wdata_pi     = wd;
    ext_req_pi       = req;
    ext_we_pi        = xwe;
    ext_adr_pi       = xadr;
    ext_wdata_pi     = xwd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_pi);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset_pi = 1'b0;
    // A pending CPU store during reset must not reach the RAM.
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555, 1'b1, 1'b1, 8'h02, 32'h6666_6666);
    repeat (2) @(posedge clk_pi);
    @(negedge clk_pi);
    vectors_applied++;
    checkOutput("reset gnt", {31'b0, ext_gnt_po}, 32'h0);
    checkOutput("reset ack", {31'b0, ext_ack_po}, 32'h0);
    checkOutput("reset stall", {31'b0, cpu_stall_po}, 32'h0);
    checkOutput("reset ram_we", {31'b0, ram_we_po}, 32'h0);
    checkOutput("reset ext_rdata", ext_rdata_po, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    reset_pi = 1'b1;
    nextCycle();

    // Columns: cpu_en we adr wdata | ext_req we adr wdata | gnt ack stall ram_we ram_a | chk_xr xr | chk_cr cr
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,8'h10,32'hDEADBEEF,  1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,8'h10,32'hDEADBEEF,  1'b1,1'b0,1'b0,1'b1,8'h10, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,8'h10,32'hDEADBEEF,  1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b1,1'b0,32'h40,32'h0,         1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h10, 1'b0,32'h0,         1'b1,32'hDEADBEEF});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h10,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h10,32'h0,         1'b1,1'b0,1'b0,1'b0,8'h10, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h10,32'h0,         1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,32'hDEADBEEF,  1'b0,32'h0});
    vecs.push_back('{1'b1,1'b1,32'h44,32'h12345678,  1'b1,1'b0,8'h11,32'h0,         1'b0,1'b0,1'b0,1'b1,8'h11, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h11,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h11,32'h0,         1'b1,1'b0,1'b0,1'b0,8'h11, 1'b0,32'h0,         1'b1,32'h12345678});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,8'h11,32'h0,         1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,32'h12345678,  1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,8'h20,32'hAAAA5555,  1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b1,1'b1,32'h80,32'hBBBBBBBB,  1'b1,1'b1,8'h20,32'hAAAA5555,  1'b1,1'b0,1'b1,1'b1,8'h20, 1'b0,32'h0,         1'b0,32'h0});
    vecs.push_back('{1'b1,1'b0,32'h80,32'h0,         1'b1,1'b1,8'h20,32'hAAAA5555,  1'b0,1'b1,1'b0,1'b0,8'h20, 1'b0,32'h0,         1'b1,32'hAAAA5555});
    vecs.push_back('{1'b1,1'b0,32'h80,32'h0,         1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h20, 1'b1,32'h12345678,  1'b1,32'hAAAA5555});
    vecs.push_back('{1'b1,1'b0,32'hFFFF0440,32'h0,   1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,1'b0,1'b0,8'h10, 1'b0,32'h0,         1'b1,32'hDEADBEEF});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cpu_en, vecs[i].cpu_we, vecs[i].cpu_adr, vecs[i].cpu_wdata,
                    vecs[i].ext_req, vecs[i].ext_we, vecs[i].ext_adr, vecs[i].ext_wdata);
      @(negedge clk_pi);
      vectors_applied++;
      checkOutput($sformatf("v%0d gnt", i), {31'b0, ext_gnt_po}, {31'b0, vecs[i].e_gnt});
      checkOutput($sformatf("v%0d ack", i), {31'b0, ext_ack_po}, {31'b0, vecs[i].e_ack});
      checkOutput($sformatf("v%0d stall", i), {31'b0, cpu_stall_po}, {31'b0, vecs[i].e_stall});
      checkOutput($sformatf("v%0d ram_we", i), {31'b0, ram_we_po}, {31'b0, vecs[i].e_we});
      checkOutput($sformatf("v%0d ram_a", i), {24'b0, ram_a_po}, {24'b0, vecs[i].e_a});
      if (vecs[i].chk_xr) checkOutput($sformatf("v%0d ext_rdata", i), ext_rdata_po, vecs[i].e_xr);
      if (vecs[i].chk_cr) checkOutput($sformatf("v%0d cpu_rdata", i), cpu_rdata_po, vecs[i].e_cr);
      nextCycle();
    end

    // Reset asserted in the middle of an external write's EXT_ACC cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D);
    @(negedge clk_pi);
    vectors_applied++;
    checkOutput("rst_seq idle gnt", {31'b0, ext_gnt_po}, 32'h0);
    nextCycle();
    @(negedge clk_pi);
    vectors_applied++;
    checkOutput("rst_seq acc gnt", {31'b0, ext_gnt_po}, 32'h1);
    checkOutput("rst_seq acc we", {31'b0, ram_we_po}, 32'h1);
    #2 reset_pi = 1'b0;
    #1;
    checkOutput("rst_seq gnt cleared", {31'b0, ext_gnt_po}, 32'h0);
    checkOutput("rst_seq we cleared", {31'b0, ram_we_po}, 32'h0);
    checkOutput("rst_seq ack cleared", {31'b0, ext_ack_po}, 32'h0);
    checkOutput("rst_seq stall cleared", {31'b0, cpu_stall_po}, 32'h0);
    checkOutput("rst_seq rdata cleared", ext_rdata_po, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk_pi);
    reset_pi = 1'b1;
    checkOutput("rst_seq ram word 0x30", mem[8'h30], 32'h0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      @(negedge clk_pi);
      vectors_applied++;
      checkOutput($sformatf("rst_seq post ack c%0d", k), {31'b0, ext_ack_po}, 32'h0);
      checkOutput($sformatf("rst_seq post gnt c%0d", k), {31'b0, ext_gnt_po}, 32'h0);
    end
    nextCycle();

    // Continuous request with the CPU idle: IDLE, EXT_ACC, EXT_ACK repeating.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_pi);
      vectors_applied++;
      checkOutput($sformatf("spacing gnt c%0d", k), {31'b0, ext_gnt_po}, {31'b0, (k % 3) == 1});
      checkOutput($sformatf("spacing ack c%0d", k), {31'b0, ext_ack_po}, {31'b0, (k % 3) == 2});
      checkOutput($sformatf("spacing stall c%0d", k), {31'b0, cpu_stall_po}, 32'h0);
      if ((k % 3) == 2) checkOutput($sformatf("spacing rdata c%0d", k), ext_rdata_po, 32'hDEADBEEF);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    nextCycle();

    // CPU busy every cycle while the external master keeps requesting.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
`ifdef RAM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 21; k++) begin
      @(negedge clk_pi);
      vectors_applied++;
      checkOutput($sformatf("guard gnt c%0d", k), {31'b0, ext_gnt_po}, {31'b0, k == 16});
      checkOutput($sformatf("guard stall c%0d", k), {31'b0, cpu_stall_po}, {31'b0, k == 16});
      checkOutput($sformatf("guard ack c%0d", k), {31'b0, ext_ack_po}, {31'b0, k == 17});
      nextCycle();
    end
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_pi);
      vectors_applied++;
      checkOutput($sformatf("starve gnt c%0d", k), {31'b0, ext_gnt_po}, 32'h0);
      checkOutput($sformatf("starve stall c%0d", k), {31'b0, cpu_stall_po}, 32'h0);
      nextCycle();
    end
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
